// File: rtl/swc_multi.sv
// Multi-channel up/down stopwatch counter driven by a single instruction stream.
// Optional feature macro: SWC_MULTI_BROADCAST_EN (chan 4'hF addresses every channel).
module swc_multi #(
    parameter int Channels = 4,
    parameter int Bytes    = 3
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [19:0]                   inst,
    input  logic                          inst_en,
    output logic [Channels*8*Bytes-1:0]   counters,
    output logic [Channels-1:0]           done,
    output logic                          ready,
    output logic                          error
);

    localparam int W = 8 * Bytes;

    typedef enum logic [3:0] {
        OP_NOP = 4'd0,
        OP_LDB = 4'd1,
        OP_COU = 4'd2,
        OP_COD = 4'd3,
        OP_CCU = 4'd4,
        OP_CCD = 4'd5,
        OP_CCS = 4'd6,
        OP_CLR = 4'd7,
        OP_WRP = 4'd8
    } op_e;

    typedef enum logic [1:0] {
        CH_IDLE = 2'd0,
        CH_UP   = 2'd1,
        CH_DOWN = 2'd2
    } ch_state_e;

    // Result of one counting step: new value, whether it landed on zero, and
    // whether the channel must drop back to Idle (stop mode boundary).
    typedef struct packed {
        logic [W-1:0] val;
        logic         hit_zero;
        logic         stop;
    } step_t;

    function automatic step_t step_up(input logic [W-1:0] v, input logic wrap);
        step_t r;
        r.val      = v + {{(W-1){1'b0}}, 1'b1};
        r.hit_zero = (r.val == {W{1'b0}});
        r.stop     = r.hit_zero & ~wrap;
        return r;
    endfunction

    // In stop mode a down-step at zero saturates silently and idles the channel.
    function automatic step_t step_down(input logic [W-1:0] v, input logic wrap);
        step_t r;
        if ((v == {W{1'b0}}) && !wrap) begin
            r.val      = v;
            r.hit_zero = 1'b0;
            r.stop     = 1'b1;
        end else begin
            r.val      = v - {{(W-1){1'b0}}, 1'b1};
            r.hit_zero = (r.val == {W{1'b0}});
            r.stop     = r.hit_zero & ~wrap;
        end
        return r;
    endfunction

    op_e          op;
    logic [3:0]   chan;
    logic [3:0]   bsel;
    logic [7:0]   data;
    logic         bcast;
    logic         inst_valid;
    logic         accept;
    logic [Channels-1:0] hit;

    logic [W-1:0]  cnt_q   [Channels];
    logic [W-1:0]  cnt_d   [Channels];
    ch_state_e     st_q    [Channels];
    ch_state_e     st_d    [Channels];
    logic [Channels-1:0] wrap_q, wrap_d;
    logic [Channels-1:0] done_q, done_d;
    logic          error_q, error_d;
    logic          ready_q, ready_d;

    assign op   = op_e'(inst[19:16]);
    assign chan = inst[15:12];
    assign bsel = inst[11:8];
    assign data = inst[7:0];

`ifdef SWC_MULTI_BROADCAST_EN
    assign bcast = (chan == 4'hF);
`else
    assign bcast = 1'b0;
`endif

    // Instruction decode: legality check and per-channel addressing.
    always_comb begin
        inst_valid = (inst[19:16] <= 4'd8)
                   && (({28'd0, chan} < Channels) || bcast)
                   && !((op == OP_LDB) && ({28'd0, bsel} >= Bytes));
        accept     = inst_en & ~error_q;
        for (int k = 0; k < Channels; k++) begin
            hit[k] = accept && inst_valid && (op != OP_NOP)
                     && (bcast || ({28'd0, chan} == k));
        end
    end

    // Next-state datapath: an addressed instruction replaces the auto step.
    always_comb begin
        error_d = error_q | (accept & ~inst_valid);
        ready_d = ~error_d;
        for (int k = 0; k < Channels; k++) begin
            step_t up_s;
            step_t dn_s;
            up_s      = step_up(cnt_q[k], wrap_q[k]);
            dn_s      = step_down(cnt_q[k], wrap_q[k]);
            cnt_d[k]  = cnt_q[k];
            st_d[k]   = st_q[k];
            wrap_d[k] = wrap_q[k];
            done_d[k] = 1'b0;
            if (error_q) begin
                cnt_d[k] = cnt_q[k];
            end else if (hit[k]) begin
                case (op)
                    OP_LDB: begin
                        for (int b = 0; b < Bytes; b++) begin
                            cnt_d[k][b*8 +: 8] = ({28'd0, bsel} == b) ? data : cnt_q[k][b*8 +: 8];
                        end
                        st_d[k] = CH_IDLE;
                    end
                    OP_COU: begin
                        cnt_d[k]  = up_s.val;
                        done_d[k] = up_s.hit_zero;
                        st_d[k]   = CH_IDLE;
                    end
                    OP_COD: begin
                        cnt_d[k]  = dn_s.val;
                        done_d[k] = dn_s.hit_zero;
                        st_d[k]   = CH_IDLE;
                    end
                    OP_CCU: begin
                        cnt_d[k]  = up_s.val;
                        done_d[k] = up_s.hit_zero;
                        st_d[k]   = up_s.stop ? CH_IDLE : CH_UP;
                    end
                    OP_CCD: begin
                        cnt_d[k]  = dn_s.val;
                        done_d[k] = dn_s.hit_zero;
                        st_d[k]   = dn_s.stop ? CH_IDLE : CH_DOWN;
                    end
                    OP_CCS: begin
                        st_d[k] = CH_IDLE;
                    end
                    OP_CLR: begin
                        cnt_d[k] = {W{1'b0}};
                        st_d[k]  = CH_IDLE;
                    end
                    OP_WRP: begin
                        wrap_d[k] = data[0];
                    end
                    default: begin
                        cnt_d[k] = cnt_q[k];
                    end
                endcase
            end else begin
                case (st_q[k])
                    CH_UP: begin
                        cnt_d[k]  = up_s.val;
                        done_d[k] = up_s.hit_zero;
                        st_d[k]   = up_s.stop ? CH_IDLE : CH_UP;
                    end
                    CH_DOWN: begin
                        cnt_d[k]  = dn_s.val;
                        done_d[k] = dn_s.hit_zero;
                        st_d[k]   = dn_s.stop ? CH_IDLE : CH_DOWN;
                    end
                    default: begin
                        st_d[k] = CH_IDLE;
                    end
                endcase
            end
        end
    end

    // State registers: global Ready/Error flag plus per-channel FSM and counters.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int k = 0; k < Channels; k++) begin
                cnt_q[k] <= {W{1'b0}};
                st_q[k]  <= CH_IDLE;
            end
            wrap_q  <= {Channels{1'b0}};
            done_q  <= {Channels{1'b0}};
            error_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            for (int k = 0; k < Channels; k++) begin
                cnt_q[k] <= cnt_d[k];
                st_q[k]  <= st_d[k];
            end
            wrap_q  <= wrap_d;
            done_q  <= done_d;
            error_q <= error_d;
            ready_q <= ready_d;
        end
    end

    for (genvar g = 0; g < Channels; g++) begin : g_out
        assign counters[g*W +: W] = cnt_q[g];
    end

    assign done  = done_q;
    assign ready = ready_q;
    assign error = error_q;

endmodule

// File: tb/tb_swc_multi.sv
// Self-checking bench for swc_multi (Channels=4, Bytes=3): behavioural model plus
// hand-computed literal checks. Honours SWC_MULTI_BROADCAST_EN if defined.
module tb_swc_multi;

    localparam int CH = 4;
    localparam int BY = 3;
    localparam int W  = 24;
    localparam longint MOD = 64'h0000_0000_0100_0000;
`ifdef SWC_MULTI_BROADCAST_EN
    localparam bit BCAST = 1'b1;
`else
    localparam bit BCAST = 1'b0;
`endif

    logic            clock = 1'b0;
    logic            reset;
    logic [19:0]     inst;
    logic            inst_en;
    logic [CH*W-1:0] counters;
    logic [CH-1:0]   done;
    logic            ready;
    logic            error;

    always #5 clock = ~clock;

    swc_multi #(.Channels(CH), .Bytes(BY)) dut (
        .clock    (clock),
        .reset    (reset),
        .inst     (inst),
        .inst_en  (inst_en),
        .counters (counters),
        .done     (done),
        .ready    (ready),
        .error    (error)
    );

    int tests = 0;
    int fails = 0;

    longint m_cnt  [CH];
    int     m_run  [CH];   // 0 idle, +1 counting up, -1 counting down
    bit     m_wrap [CH];
    bit     m_done [CH];
    bit     m_err;
    bit     m_valid = 1'b0;

    task automatic cmp(input string name, input logic [95:0] act, input logic [95:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void m_step(input int k, input int dir);
        if (dir > 0) begin
            m_cnt[k] = (m_cnt[k] + 1) % MOD;
            if (m_cnt[k] == 0) begin
                m_done[k] = 1'b1;
                if (!m_wrap[k]) m_run[k] = 0;
            end
        end else if (m_cnt[k] == 0 && !m_wrap[k]) begin
            m_run[k] = 0;
        end else begin
            m_cnt[k] = (m_cnt[k] + MOD - 1) % MOD;
            if (m_cnt[k] == 0) begin
                m_done[k] = 1'b1;
                if (!m_wrap[k]) m_run[k] = 0;
            end
        end
    endfunction

    task automatic model_update(input bit rst, input bit en, input bit [3:0] op,
                                input bit [3:0] chan, input bit [3:0] bsel, input bit [7:0] data);
        bit valid;
        bit tgt;
        if (!rst) begin
            for (int k = 0; k < CH; k++) begin
                m_cnt[k] = 0; m_run[k] = 0; m_wrap[k] = 0; m_done[k] = 0;
            end
            m_err   = 1'b0;
            m_valid = 1'b1;
            return;
        end
        for (int k = 0; k < CH; k++) m_done[k] = 1'b0;
        if (m_err) return;
        valid = (op <= 8) && ((chan < CH) || (BCAST && chan == 15)) && !(op == 1 && bsel >= BY);
        for (int k = 0; k < CH; k++) begin
            tgt = en && valid && (op != 0) && ((chan == k) || (chan == 15));
            if (tgt) begin
                case (op)
                    1: begin
                        m_cnt[k] = (m_cnt[k] & ~(64'hFF << (8 * bsel))) | (longint'(data) << (8 * bsel));
                        m_run[k] = 0;
                    end
                    2: begin m_step(k, 1);  m_run[k] = 0; end
                    3: begin m_step(k, -1); m_run[k] = 0; end
                    4: begin m_run[k] = 1;  m_step(k, 1);  end
                    5: begin m_run[k] = -1; m_step(k, -1); end
                    6: m_run[k] = 0;
                    7: begin m_cnt[k] = 0; m_run[k] = 0; end
                    8: m_wrap[k] = data[0];
                    default: ;
                endcase
            end else if (m_run[k] != 0) begin
                m_step(k, m_run[k]);
            end
        end
        if (en && !valid) m_err = 1'b1;
    endtask

    task automatic check_model();
        logic [CH*W-1:0] ec;
        logic [CH-1:0]   ed;
        for (int k = 0; k < CH; k++) begin
            ec[k*W +: W] = m_cnt[k][W-1:0];
            ed[k]        = m_done[k];
        end
        cmp("model_counters", counters, ec);
        cmp("model_done", done, ed);
        cmp("model_ready", ready, !m_err);
        cmp("model_error", error, m_err);
    endtask

    task automatic do_cycle(input bit rst, input bit en, input bit [3:0] op,
                            input bit [3:0] chan, input bit [3:0] bsel, input bit [7:0] data);
        reset   = rst;
        inst_en = en;
        inst    = {op, chan, bsel, data};
        model_update(rst, en, op, chan, bsel, data);
        @(negedge clock);
        if (m_valid) check_model();
    endtask

    task automatic ins(input bit [3:0] op, input bit [3:0] chan, input bit [3:0] bsel, input bit [7:0] data);
        do_cycle(1'b1, 1'b1, op, chan, bsel, data);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) do_cycle(1'b1, 1'b0, 4'h0, 4'h0, 4'h0, 8'h00);
    endtask

    task automatic rst_pulse();
        do_cycle(1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 8'h00);
    endtask

    task automatic lit_ch(input string name, input int k, input logic [23:0] v);
        cmp(name, counters[k*W +: W], v);
    endtask

    initial begin
        reset = 1'b1; inst_en = 1'b0; inst = 20'h00000;
        @(negedge clock);
        rst_pulse(); rst_pulse();
        cmp("reset_counters", counters, 96'd0);
        cmp("reset_ready", ready, 1'b1);
        cmp("reset_error", error, 1'b0);
        cmp("reset_done", done, 4'b0000);

        // ch2 load 3, count down to zero
        ins(4'h1, 4'h2, 4'h0, 8'h03); ins(4'h1, 4'h2, 4'h1, 8'h00); ins(4'h1, 4'h2, 4'h2, 8'h00);
        lit_ch("ldb_ch2", 2, 24'h000003);
        ins(4'h5, 4'h2, 4'h0, 8'h00);
        lit_ch("ccd_ch2_2", 2, 24'h000002);
        idle(1); lit_ch("ccd_ch2_1", 2, 24'h000001);
        idle(1); lit_ch("ccd_ch2_0", 2, 24'h000000);
        cmp("ccd_ch2_done", done, 4'b0100);
        idle(1); lit_ch("ccd_ch2_hold", 2, 24'h000000);
        cmp("ccd_ch2_done_once", done, 4'b0000);

        // ch1 up through all-ones in stop mode
        ins(4'h1, 4'h1, 4'h0, 8'hFD); ins(4'h1, 4'h1, 4'h1, 8'hFF); ins(4'h1, 4'h1, 4'h2, 8'hFF);
        ins(4'h4, 4'h1, 4'h0, 8'h00); lit_ch("ccu_ch1_fe", 1, 24'hFFFFFE);
        idle(1); lit_ch("ccu_ch1_ff", 1, 24'hFFFFFF);
        idle(1); lit_ch("ccu_ch1_0", 1, 24'h000000);
        cmp("ccu_ch1_done", done, 4'b0010);
        idle(1); lit_ch("ccu_ch1_stop", 1, 24'h000000);

        // same with wrap enabled
        ins(4'h8, 4'h1, 4'h0, 8'h01);
        ins(4'h1, 4'h1, 4'h0, 8'hFD); ins(4'h1, 4'h1, 4'h1, 8'hFF); ins(4'h1, 4'h1, 4'h2, 8'hFF);
        ins(4'h4, 4'h1, 4'h0, 8'h00); idle(2);
        cmp("wrap_ch1_done", done, 4'b0010);
        idle(2); lit_ch("wrap_ch1_2", 1, 24'h000002);
        ins(4'h6, 4'h1, 4'h0, 8'h00); lit_ch("ccs_ch1_hold", 1, 24'h000002);
        ins(4'h7, 4'h1, 4'h0, 8'h00); ins(4'h3, 4'h1, 4'h0, 8'h00);
        lit_ch("wrap_cod_0", 1, 24'hFFFFFF);
        ins(4'h8, 4'h1, 4'h0, 8'h00);

        // concurrent ch0 up / ch3 down
        ins(4'h1, 4'h3, 4'h0, 8'h05);
        ins(4'h4, 4'h0, 4'h0, 8'h00);
        ins(4'h5, 4'h3, 4'h0, 8'h00);
        lit_ch("conc_ch0", 0, 24'h000002); lit_ch("conc_ch3", 3, 24'h000004);
        idle(1);
        ins(4'h6, 4'h0, 4'h0, 8'h00);
        idle(2);
        lit_ch("ccs_ch0_frozen", 0, 24'h000003);
        cmp("ch3_done", done, 4'b1000);
        idle(1);

        // re-issue CCU, LDB stops a run, stop-mode boundaries
        ins(4'h4, 4'h0, 4'h0, 8'h00); ins(4'h4, 4'h0, 4'h0, 8'h00);
        lit_ch("reissue_ccu", 0, 24'h000005);
        ins(4'h1, 4'h0, 4'h0, 8'h10); idle(1);
        lit_ch("ldb_stops_run", 0, 24'h000010);
        ins(4'h7, 4'h0, 4'h0, 8'h00); ins(4'h3, 4'h0, 4'h0, 8'h00);
        lit_ch("cod_at_zero", 0, 24'h000000);
        cmp("cod_at_zero_done", done, 4'b0000);
        ins(4'h1, 4'h0, 4'h0, 8'hFF); ins(4'h1, 4'h0, 4'h1, 8'hFF); ins(4'h1, 4'h0, 4'h2, 8'hFF);
        ins(4'h2, 4'h0, 4'h0, 8'h00);
        cmp("cou_ones_done", done, 4'b0001);
        lit_ch("cou_ones_zero", 0, 24'h000000);

        // error state
        ins(4'h4, 4'h0, 4'h0, 8'h00);
        ins(4'hB, 4'h0, 4'h0, 8'h00);
        cmp("err_ready", ready, 1'b0);
        cmp("err_error", error, 1'b1);
        ins(4'h1, 4'h0, 4'h0, 8'h55); idle(2);
        lit_ch("err_frozen", 0, 24'h000002);
        rst_pulse();
        cmp("err_reset_counters", counters, 96'd0);
        cmp("err_reset_ready", ready, 1'b1);
        ins(4'h1, 4'h0, 4'h3, 8'hAA);
        cmp("bad_bsel", error, 1'b1);
        rst_pulse();
        ins(4'h2, 4'h4, 4'h0, 8'h00);
        cmp("bad_chan4", error, 1'b1);
        rst_pulse();

        // reset during a count
        ins(4'h4, 4'h0, 4'h0, 8'h00); idle(1);
        do_cycle(1'b0, 1'b1, 4'h4, 4'h0, 4'h0, 8'h00);
        cmp("rst_mid_count", counters, 96'd0);
        idle(3);
        cmp("rst_stays_idle", counters, 96'd0);

        // broadcast
        ins(4'h7, 4'hF, 4'h0, 8'h00);
`ifdef SWC_MULTI_BROADCAST_EN
        ins(4'h4, 4'hF, 4'h0, 8'h00);
        cmp("bcast_1", counters, {24'h000001, 24'h000001, 24'h000001, 24'h000001});
        idle(2);
        cmp("bcast_3", counters, {24'h000003, 24'h000003, 24'h000003, 24'h000003});
`else
        cmp("bcast_invalid", error, 1'b1);
`endif
        rst_pulse(); idle(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
